// File: rtl/nios2_onchip_mem_loader.sv
// Boot-image loader for the on-chip RAM's second slave port.
// It packs a little-endian byte stream into words, writes them, then reads them back and checks a word-sum checksum.
module nios2_onchip_mem_loader #(
  parameter int ADDR_W    = 13,
  parameter int DEPTH     = 8192,
  parameter int BASE_WORD = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [13:0]       length_words,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

  localparam logic [14:0] MAX_LEN = 15'(DEPTH - BASE_WORD);

  state_t      state, state_nx;
  logic [13:0] len_q;
  logic [13:0] word_cnt;
  logic [13:0] rd_cnt;
  logic [13:0] smp_cnt;
  logic [1:0]  byte_cnt;
  logic [23:0] pack;
  logic [31:0] rb_sum;
  logic        rd_vld_p1;
  logic        byte_xfer;

  function automatic logic [31:0] sum_wrap(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

  function automatic logic [ADDR_W-1:0] word_addr(input logic [13:0] idx);
    return ADDR_W'(BASE_WORD + int'(idx));
  endfunction

  assign in_ready       = (state == LOAD) && (word_cnt < len_q);
  assign byte_xfer      = in_valid && in_ready;
  assign mem_byteenable = 4'b1111;
  assign mem_clken      = 1'b1;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (length_words == 14'd0 || {1'b0, length_words} > MAX_LEN) state_nx = DONE;
          else                                                          state_nx = LOAD;
        end
      end
      // word_cnt already counts the word being written, so equality marks the final write
      LOAD:    if (mem_write && word_cnt == len_q) state_nx = VERIFY;
      VERIFY:  if (rd_vld_p1 && smp_cnt == len_q - 14'd1) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      checksum       <= '0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= word_addr(14'd0);
      mem_writedata  <= '0;
      len_q          <= '0;
      word_cnt       <= '0;
      rd_cnt         <= '0;
      smp_cnt        <= '0;
      byte_cnt       <= '0;
      pack           <= '0;
      rb_sum         <= '0;
      rd_vld_p1      <= 1'b0;
    end else begin
      state     <= state_nx;
      busy      <= (state_nx == LOAD) || (state_nx == VERIFY);
      done      <= (state_nx == DONE);
      mem_write <= 1'b0;
      rd_vld_p1 <= (state == VERIFY) && mem_chipselect;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            checksum       <= '0;
            error          <= (length_words != 14'd0) && ({1'b0, length_words} > MAX_LEN);
            len_q          <= length_words;
            word_cnt       <= '0;
            rd_cnt         <= '0;
            smp_cnt        <= '0;
            byte_cnt       <= '0;
            rb_sum         <= '0;
            mem_chipselect <= 1'b0;
            mem_address    <= word_addr(14'd0);
          end
        end
        // stage p0: byte packing, word write and running checksum
        LOAD: begin
          mem_chipselect <= 1'b0;
          if (byte_xfer) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: pack[7:0]   <= in_data;
              2'd1: pack[15:8]  <= in_data;
              2'd2: pack[23:16] <= in_data;
              default: begin
                mem_writedata  <= {in_data, pack};
                mem_chipselect <= 1'b1;
                mem_write      <= 1'b1;
                mem_address    <= word_addr(word_cnt);
                checksum       <= sum_wrap(checksum, {in_data, pack});
                word_cnt       <= word_cnt + 14'd1;
              end
            endcase
          end
          if (state_nx == VERIFY) begin
            mem_chipselect <= 1'b1;
            mem_address    <= word_addr(14'd0);
            rd_cnt         <= 14'd1;
          end
        end
        // stage p1: read data arrives one cycle behind its address
        VERIFY: begin
          if (rd_cnt < len_q) begin
            mem_address <= word_addr(rd_cnt);
            rd_cnt      <= rd_cnt + 14'd1;
          end else begin
            mem_chipselect <= 1'b0;
          end
          if (rd_vld_p1) begin
            rb_sum  <= sum_wrap(rb_sum, mem_readdata);
            smp_cnt <= smp_cnt + 14'd1;
          end
          if (state_nx == DONE) error <= (sum_wrap(rb_sum, mem_readdata) != checksum);
        end
        default: ;
      endcase
    end
  end

endmodule
